// File: rtl/genius_game_ctrl.sv
// Genius game sequencer: loads a random colour sequence, plays back the
// current round on the LEDs, checks player presses and decides win or lose.
module genius_game_ctrl #(
  parameter int unsigned MAX_ROUNDS     = 16,
  parameter int unsigned SHOW_CYCLES    = 8,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        R,
  input  logic        start,
  output logic        seq_load,
  input  logic [63:0] seq_q,
  input  logic [3:0]  btn,
  output logic [3:0]  led,
  output logic [4:0]  round,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  localparam int unsigned TMAX0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    ROUND_MAX = 5'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    StIdle, StLoad, StShowOn, StShowOff, StWaitIn, StRoundGap, StWin, StLose
  } state_e;

  state_e        state;
  logic [3:0]    idx;
  logic [TW-1:0] timer;
  logic [3:0]    echo;
  logic [3:0]    nib;
  logic          last_idx;

  assign nib      = seq_q[{idx, 2'b00} +: 4];
  assign last_idx = ({1'b0, idx} == (round - 5'd1));

  always_ff @(posedge CLK) begin
    if (R) begin
      state <= StIdle;
      idx   <= '0;
      timer <= '0;
      round <= '0;
      echo  <= '0;
    end else begin
      case (state)
        StIdle, StWin, StLose: begin
          if (start) begin
            state <= StLoad;
            round <= 5'd1;
          end
        end
        StLoad: begin
          state <= StShowOn;
          idx   <= '0;
          timer <= '0;
        end
        StShowOn: begin
          if (timer == SHOW_LAST) begin
            state <= StShowOff;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StShowOff: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (last_idx) begin
              state <= StWaitIn;
              idx   <= '0;
              echo  <= '0;
            end else begin
              state <= StShowOn;
              idx   <= idx + 4'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StWaitIn: begin
          echo <= btn;
          // A press always wins over an expiring timer on the same cycle.
          if (btn == 4'h0) begin
            if (timer == TO_LAST) state <= StLose;
            else timer <= timer + 1'b1;
          end else if (btn == nib) begin
            if (!last_idx) begin
              idx   <= idx + 4'd1;
              timer <= '0;
            end else if (round == ROUND_MAX) begin
              state <= StWin;
            end else begin
              round <= round + 5'd1;
              state <= StRoundGap;
              timer <= '0;
            end
          end else begin
            state <= StLose;
          end
        end
        StRoundGap: begin
          if (timer == GAP_LAST) begin
            state <= StShowOn;
            idx   <= '0;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    led = 4'h0;
    case (state)
      StShowOn: led = nib;
      StWaitIn: led = echo;
      default:  led = 4'h0;
    endcase
  end

  assign seq_load = (state == StLoad);
  assign win      = (state == StWin);
  assign lose     = (state == StLose);
  assign busy     = !((state == StIdle) || (state == StWin) || (state == StLose));

endmodule

// File: tb/tb_genius_game_ctrl.sv
// Directed bench for genius_game_ctrl; the bench also models the sequence
// register that seq_load writes.
module tb_genius_game_ctrl;

  localparam logic [63:0] S1 = 64'h8421_8421_8421_8421;
  localparam logic [63:0] S2 = 64'h1248_1248_1248_1248;

  logic        CLK = 1'b0;
  logic        R, start, seq_load, busy, win, lose;
  logic [3:0]  btn, led;
  logic [4:0]  round;
  logic [63:0] seq_q, seq_in;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  genius_game_ctrl #(
    .MAX_ROUNDS    (3),
    .SHOW_CYCLES   (8),
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .CLK     (CLK),
    .R       (R),
    .start   (start),
    .seq_load(seq_load),
    .seq_q   (seq_q),
    .btn     (btn),
    .led     (led),
    .round   (round),
    .busy    (busy),
    .win     (win),
    .lose    (lose)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK) if (seq_load) seq_q <= seq_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'h0;
  endtask

  // Leaves the DUT in the first SHOW_ON cycle.
  task automatic start_game;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_pulse", seq_load, 1);
    check("load_round", round, 1);
    check("load_busy", busy, 1);
    check("load_win", win, 0);
    check("load_lose", lose, 0);
    tick();
    check("load_once", seq_load, 0);
  endtask

  task automatic show_colour(input logic [3:0] c, input bit noisy, input logic [4:0] r);
    for (int i = 0; i < 8; i++) begin
      check("show_led", led, c);
      if (noisy) begin
        check("show_round", round, r);
        check("show_noload", seq_load, 0);
        if (i == 3) begin
          btn   = 4'hf;
          start = 1'b1;
        end
      end
      tick();
      btn   = 4'h0;
      start = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      check("gap_led", led, 0);
      if (noisy && i == 0) btn = c;
      tick();
      btn = 4'h0;
    end
  endtask

  task automatic play_round(input logic [63:0] s, input logic [4:0] r, input bit noisy);
    for (int i = 0; i < int'(r); i++) show_colour(s[4*i +: 4], noisy, r);
    check("wait_busy", busy, 1);
    check("wait_led", led, 0);
  endtask

  task automatic press_all(input logic [63:0] s, input logic [4:0] r);
    for (int i = 0; i < int'(r); i++) begin
      press(s[4*i +: 4]);
      if (i < int'(r) - 1) check("echo_led", led, s[4*i +: 4]);
    end
  endtask

  task automatic round_gap;
    for (int i = 0; i < 2; i++) begin
      check("rgap_led", led, 0);
      check("rgap_busy", busy, 1);
      tick();
    end
  endtask

  initial begin
    R = 1'b1; start = 1'b0; btn = 4'h0; seq_in = S1;
    tick();
    tick();
    R = 1'b0;
    check("rst_led", led, 0);
    check("rst_round", round, 0);
    check("rst_load", seq_load, 0);
    check("rst_busy", busy, 0);
    check("rst_win", win, 0);
    check("rst_lose", lose, 0);

    // Reset while a colour is being shown.
    start_game();
    tick();
    tick();
    check("mid_led", led, 1);
    R = 1'b1;
    tick();
    R = 1'b0;
    check("midrst_led", led, 0);
    check("midrst_round", round, 0);
    check("midrst_busy", busy, 0);
    check("midrst_load", seq_load, 0);
    tick();
    check("midrst_load2", seq_load, 0);
    check("midrst_busy2", busy, 0);

    // Round 1, then round 2 playback and a wrong second press.
    start_game();
    play_round(S1, 5'd1, 1'b0);
    press_all(S1, 5'd1);
    check("r2_round", round, 2);
    check("r2_led", led, 0);
    round_gap();
    play_round(S1, 5'd2, 1'b0);
    press(4'h1);
    check("ok_echo", led, 1);
    check("ok_busy", busy, 1);
    press(4'h4);
    check("wrong_lose", lose, 1);
    check("wrong_busy", busy, 0);
    check("wrong_round", round, 2);
    check("wrong_led", led, 0);
    tick();
    check("lose_hold", lose, 1);

    // Timeout: a press at the last allowed cycle survives, silence does not.
    seq_in = S2;
    start_game();
    play_round(S2, 5'd1, 1'b0);
    repeat (63) tick();
    check("late_lose", lose, 0);
    check("late_busy", busy, 1);
    press(4'h8);
    check("late_round", round, 2);
    check("late_busy2", busy, 1);
    round_gap();
    play_round(S2, 5'd2, 1'b0);
    repeat (63) tick();
    check("to_early", lose, 0);
    tick();
    check("to_lose", lose, 1);
    check("to_round", round, 2);

    // Full game to WIN with three rounds, then restart.
    seq_in = S1;
    start_game();
    play_round(S1, 5'd1, 1'b0);
    press_all(S1, 5'd1);
    round_gap();
    play_round(S1, 5'd2, 1'b0);
    press_all(S1, 5'd2);
    check("r3_round", round, 3);
    round_gap();
    play_round(S1, 5'd3, 1'b0);
    press_all(S1, 5'd3);
    check("win_win", win, 1);
    check("win_busy", busy, 0);
    check("win_round", round, 3);
    check("win_led", led, 0);
    tick();
    check("win_hold", win, 1);
    start_game();

    // Ignored btn/start during playback, then a multi-bit press loses.
    play_round(S1, 5'd1, 1'b1);
    press(4'h3);
    check("multi_lose", lose, 1);
    check("multi_round", round, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
